hazard_fwd_unit: RTL and testbench
==================================

HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-address width.
REQ-002 SHALL have parameter FWD_SEL_W, default 2, select width driving the operand Mux_3x1 sel inputs.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 id_valid  input  1  ID-stage instruction present.
REQ-006 id_rs1, id_rs2  input  REG_ADDR_W each  ID source registers.
REQ-007 id_rd  input  REG_ADDR_W  ID destination register.
REQ-008 id_reg_write, id_mem_read  input  1 each  ID writes RF / ID is a load.
REQ-009 ex_branch_taken  input  1  EX-stage branch/jump resolved taken.
REQ-010 stall  output  1  hold PC and IF/ID register.
REQ-011 flush  output  1  kill IF/ID contents.
REQ-012 fwd_a_sel, fwd_b_sel  output  FWD_SEL_W each  EX operand mux selects.

Function
REQ-013 SHALL track three internal slots (EX, MEM, WB), each holding valid, rs1, rs2, rd, reg_write, mem_read; slots advance ID->EX->MEM->WB every cycle.
REQ-014 Select encoding SHALL be 2'b00 = RF, 2'b01 = MEM result, 2'b10 = WB result; 2'b11 SHALL never be driven.
REQ-015 fwd_a_sel SHALL be 01 when MEM.valid & MEM.reg_write & MEM.rd != 0 & MEM.rd == EX.rs1; else 10 under the same test against WB; else 00. fwd_b_sel is identical using EX.rs2.
REQ-016 MEM match SHALL take priority over WB match for the same operand.
REQ-017 Selects SHALL be combinational from slot registers (zero latency relative to EX contents); 00 when EX.valid = 0.
REQ-018 Register x0 (rd == 0) SHALL never produce forwarding or stall.
REQ-019 Load-use: stall SHALL assert combinationally when id_valid & EX.valid & EX.mem_read & EX.reg_write & EX.rd != 0 & (EX.rd == id_rs1 or EX.rd == id_rs2).
REQ-020 FSM states: RUN, LU_BUBBLE. RUN->LU_BUBBLE on load-use stall; LU_BUBBLE->RUN unconditionally next cycle.
REQ-021 During stall cycle, EX slot SHALL load a bubble (valid = 0); MEM/WB advance normally; ID is re-presented next cycle.
REQ-022 At most one consecutive stall cycle per load; the following cycle forwards via MEM->WB path (sel 10).
REQ-023 flush SHALL equal ex_branch_taken combinationally; on flush, EX slot SHALL load a bubble regardless of id_valid.
REQ-024 Simultaneous flush and load-use condition: flush wins, stall SHALL be 0, FSM stays/returns to RUN.
REQ-025 When id_valid = 0, EX SHALL load a bubble and stall SHALL be 0.

Reset
REQ-026 On rst assertion, all slot valid bits SHALL clear immediately, FSM SHALL enter RUN.
REQ-027 During and after reset: stall = 0, flush = ex_branch_taken, fwd_a_sel = fwd_b_sel = 00.
REQ-028 Reset mid-stall SHALL abort the stall with no residual bubble or counter change.

Configuration
REQ-029 Macro HAZARD_PERF_CNT_EN SHALL add outputs stall_count and flush_count (32 bits each), incrementing once per cycle of stall/flush, saturating at 32'hFFFF_FFFF, cleared by rst.
REQ-030 Without HAZARD_PERF_CNT_EN, those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-031 hazard_pkg SHALL hold fwd_sel_e enum (FWD_RF, FWD_MEM, FWD_WB), pipe_slot_t struct, and FSM state enum.
REQ-032 One sub-module fwd_select SHALL compute one operand select from (rs, MEM slot, WB slot); instantiated twice.

Verification
REQ-033 add x5 in MEM, EX reads rs1 = x5 -> fwd_a_sel = 01, fwd_b_sel = 00.
REQ-034 x7 written in both MEM and WB, EX rs2 = x7 -> fwd_b_sel = 01 (MEM priority).
REQ-035 lw x3 in EX, ID rs1 = x3 -> stall = 1 for exactly 1 cycle, EX bubble; next cycle fwd_a_sel = 10.
REQ-036 Load-use on x3 plus ex_branch_taken = 1 same cycle -> flush = 1, stall = 0, EX bubble.
REQ-037 Instruction writing x0 in MEM, EX rs1 = x0 -> fwd_a_sel = 00; lw x0 -> no stall.
REQ-038 rst asserted during LU_BUBBLE -> all selects 00, stall 0 asynchronously; (with HAZARD_PERF_CNT_EN) counters read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding unit: operand select codes, pipeline slot record, FSM states.
// Address fields are sized for the widest supported register file; narrower addresses are zero-extended.
package hazard_pkg;

    localparam int REG_ADDR_W_MAX = 8;

    typedef logic [REG_ADDR_W_MAX-1:0] slot_addr_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic       valid;
        slot_addr_t rs1;
        slot_addr_t rs2;
        slot_addr_t rd;
        logic       reg_write;
        logic       mem_read;
    } pipe_slot_t;

    typedef enum logic [0:0] {
        ST_RUN       = 1'b0,
        ST_LU_BUBBLE = 1'b1
    } hz_state_e;

    localparam pipe_slot_t BUBBLE = '0;

    // True when slot s will write register r; x0 never counts as a producer.
    function automatic logic produces(input pipe_slot_t s, input slot_addr_t r);
        return s.valid && s.reg_write && (s.rd != '0) && (s.rd == r);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding select for one EX source register; the MEM producer beats the WB producer.
import hazard_pkg::*;

module fwd_select #(
    parameter int FWD_SEL_W = 2
) (
    input  logic                 ex_valid,
    input  slot_addr_t           rs,
    input  pipe_slot_t           mem_slot,
    input  pipe_slot_t           wb_slot,
    output logic [FWD_SEL_W-1:0] sel
);

    fwd_sel_e sel_e;

    always_comb begin
        sel_e = FWD_RF;
        if (ex_valid) begin
            if (produces(mem_slot, rs)) begin
                sel_e = FWD_MEM;
            end else if (produces(wb_slot, rs)) begin
                sel_e = FWD_WB;
            end
        end
    end

    assign sel = FWD_SEL_W'(sel_e);

    logic unused_slot_bits;
    assign unused_slot_bits = ^{mem_slot.rs1, mem_slot.rs2, mem_slot.mem_read,
                                wb_slot.rs1, wb_slot.rs2, wb_slot.mem_read};

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and EX operand forwarding for a 5-stage pipeline (tracks EX/MEM/WB slots).
// Optional HAZARD_PERF_CNT_EN adds saturating 32-bit stall_count/flush_count outputs.
//
// state        | meaning
// ST_RUN       | normal issue; load-use detection armed
// ST_LU_BUBBLE | one bubble inserted behind a load; ID re-presented
import hazard_pkg::*;

module hazard_fwd_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int FWD_SEL_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  ex_branch_taken,
    output logic                  stall,
    output logic                  flush,
    output logic [FWD_SEL_W-1:0]  fwd_a_sel,
    output logic [FWD_SEL_W-1:0]  fwd_b_sel
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           stall_count,
    output logic [31:0]           flush_count
`endif
);

    pipe_slot_t ex_q, mem_q, wb_q;
    pipe_slot_t id_slot, ex_d;
    hz_state_e  state_q, state_d;
    logic       load_use;

    always_comb begin
        id_slot           = BUBBLE;
        id_slot.valid     = id_valid;
        id_slot.rs1       = slot_addr_t'(id_rs1);
        id_slot.rs2       = slot_addr_t'(id_rs2);
        id_slot.rd        = slot_addr_t'(id_rd);
        id_slot.reg_write = id_reg_write;
        id_slot.mem_read  = id_mem_read;
    end

    assign load_use = id_valid && ex_q.mem_read &&
                      (produces(ex_q, id_slot.rs1) || produces(ex_q, id_slot.rs2));

    // A taken branch kills the dependent instruction, so there is nothing to stall for.
    assign flush = ex_branch_taken;
    assign stall = load_use && !flush && (state_q == ST_RUN);

    always_comb begin
        ex_d = id_slot;
        if (flush || stall || !id_valid) begin
            ex_d = BUBBLE;
        end
    end

    always_comb begin
        state_d = ST_RUN;
        case (state_q)
            ST_RUN:       state_d = stall ? ST_LU_BUBBLE : ST_RUN;
            ST_LU_BUBBLE: state_d = ST_RUN;
            default:      state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q    <= BUBBLE;
            mem_q   <= BUBBLE;
            wb_q    <= BUBBLE;
            state_q <= ST_RUN;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= ex_q;
            wb_q    <= mem_q;
            state_q <= state_d;
        end
    end

    fwd_select #(.FWD_SEL_W(FWD_SEL_W)) u_fwd_a (
        .ex_valid (ex_q.valid),
        .rs       (ex_q.rs1),
        .mem_slot (mem_q),
        .wb_slot  (wb_q),
        .sel      (fwd_a_sel)
    );

    fwd_select #(.FWD_SEL_W(FWD_SEL_W)) u_fwd_b (
        .ex_valid (ex_q.valid),
        .rs       (ex_q.rs2),
        .mem_slot (mem_q),
        .wb_slot  (wb_q),
        .sel      (fwd_b_sel)
    );

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && (stall_count != 32'hFFFF_FFFF)) begin
                stall_count <= stall_count + 32'd1;
            end
            if (flush && (flush_count != 32'hFFFF_FFFF)) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: forwarding priority, load-use bubble, flush, x0, async reset.
module tb_hazard_fwd_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_reg_write, id_mem_read;
    logic       ex_branch_taken;
    logic       stall, flush;
    logic [1:0] fwd_a_sel, fwd_b_sel;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_count, flush_count;
`endif

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hazard_fwd_unit #(.REG_ADDR_W(5), .FWD_SEL_W(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .stall           (stall),
        .flush           (flush),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_count     (stall_count),
        .flush_count     (flush_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic rw, input logic mr);
        id_valid     = v;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_rd        = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
    endtask

    task automatic idle;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        ex_branch_taken = 1'b0;
        idle();
        #2;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_fwd_a", 32'(fwd_a_sel), 32'd0);
        chk("rst_fwd_b", 32'(fwd_b_sel), 32'd0);
        ex_branch_taken = 1'b1;
        #1;
        chk("rst_flush_follows_branch", 32'(flush), 32'd1);
        ex_branch_taken = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
        chk("rst_stall_count", stall_count, 32'd0);
        chk("rst_flush_count", flush_count, 32'd0);
`endif
        tick();
        tick();
        rst = 1'b0;

        // add x5 in MEM, EX reads x5 on rs1
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd5, 5'd6, 5'd8, 1'b1, 1'b0);
        tick();
        idle();
        #1;
        chk("mem_fwd_a", 32'(fwd_a_sel), 32'd1);
        chk("mem_fwd_b", 32'(fwd_b_sel), 32'd0);
        chk("mem_fwd_stall", 32'(stall), 32'd0);

        // x7 produced in both MEM and WB: MEM wins
        set_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd1, 5'd7, 5'd9, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 5'd7, 5'd7, 5'd11, 1'b0, 1'b0);
        #1;
        chk("prio_fwd_b", 32'(fwd_b_sel), 32'd1);
        chk("prio_fwd_a", 32'(fwd_a_sel), 32'd0);
        tick();
        idle();
        #1;
        chk("wb_fwd_a", 32'(fwd_a_sel), 32'd2);
        chk("wb_fwd_b", 32'(fwd_b_sel), 32'd2);

        // lw x3 followed by a consumer of x3
        set_id(1'b1, 5'd2, 5'd0, 5'd3, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd3, 5'd4, 5'd10, 1'b1, 1'b0);
        #1;
        chk("lu_stall", 32'(stall), 32'd1);
        chk("lu_flush", 32'(flush), 32'd0);
        tick();
        #1;
        chk("lu_single_stall", 32'(stall), 32'd0);
        chk("lu_bubble_fwd_a", 32'(fwd_a_sel), 32'd0);
        tick();
        idle();
        #1;
        chk("lu_after_fwd_a", 32'(fwd_a_sel), 32'd2);
        chk("lu_after_fwd_b", 32'(fwd_b_sel), 32'd0);
        chk("lu_after_stall", 32'(stall), 32'd0);

        // load-use coinciding with a taken branch
        set_id(1'b1, 5'd2, 5'd0, 5'd3, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd4, 5'd3, 5'd12, 1'b1, 1'b0);
        ex_branch_taken = 1'b1;
        #1;
        chk("flush_lu_flush", 32'(flush), 32'd1);
        chk("flush_lu_stall", 32'(stall), 32'd0);
        tick();
        ex_branch_taken = 1'b0;
        idle();
        #1;
        chk("flush_deassert", 32'(flush), 32'd0);
        chk("flush_bubble_fwd_b", 32'(fwd_b_sel), 32'd0);
        // FSM must still be in RUN: a fresh load-use via rs2 stalls
        set_id(1'b1, 5'd2, 5'd0, 5'd3, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd0, 5'd3, 5'd13, 1'b1, 1'b0);
        #1;
        chk("lu_rs2_stall", 32'(stall), 32'd1);
        tick();
        idle();
        tick();
        tick();
        tick();

        // x0 never forwards and never stalls
        set_id(1'b1, 5'd1, 5'd1, 5'd0, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd14, 1'b1, 1'b0);
        tick();
        idle();
        #1;
        chk("x0_fwd_a", 32'(fwd_a_sel), 32'd0);
        chk("x0_fwd_b", 32'(fwd_b_sel), 32'd0);
        set_id(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd15, 1'b1, 1'b0);
        #1;
        chk("x0_lw_stall", 32'(stall), 32'd0);
        tick();
        idle();
        tick();
        tick();
        tick();

        // async reset clears an active forward immediately
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd5, 5'd0, 5'd17, 1'b1, 1'b0);
        tick();
        idle();
        #1;
        chk("pre_rst_fwd_a", 32'(fwd_a_sel), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_fwd_a", 32'(fwd_a_sel), 32'd0);
        tick();
        rst = 1'b0;

        // reset during LU_BUBBLE
        set_id(1'b1, 5'd2, 5'd0, 5'd3, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd3, 5'd0, 5'd16, 1'b1, 1'b0);
        #1;
        chk("lu2_stall", 32'(stall), 32'd1);
        tick();
        #1;
        rst = 1'b1;
        #1;
        chk("lub_rst_stall", 32'(stall), 32'd0);
        chk("lub_rst_fwd_a", 32'(fwd_a_sel), 32'd0);
        chk("lub_rst_fwd_b", 32'(fwd_b_sel), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        chk("lub_rst_stall_count", stall_count, 32'd0);
        chk("lub_rst_flush_count", flush_count, 32'd0);
`endif
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_stall", 32'(stall), 32'd0);
        tick();
        idle();
        #1;
        chk("post_rst_no_residual_fwd_a", 32'(fwd_a_sel), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
